// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_sched
// Purpose : Round-robin scheduler sharing one trigger-started UART transmitter
//           between NUM_REQ byte producers; owns all frame and gap timing.
// Revision: 1.0
// ============================================================================
module uart_tx_sched #(
   parameter int NUM_REQ    = 4,
   parameter int BIT_CYCLES = 2,
   parameter int GAP_CYCLES = 2,
   parameter int CNT_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_trigger,
   output logic [7:0]                 tx_data,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       frame_done
);

   localparam int IDX_W = $clog2(NUM_REQ);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_TRIG = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   localparam logic [IDX_W:0]   c_num_req   = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] c_last_init = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] c_send_last = CNT_W'(11*BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam bit               c_has_gap   = (GAP_CYCLES > 0);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_last;
   logic [IDX_W-1:0] r_grant_id;
   logic [7:0]       r_tx_data;
   logic             r_busy;
   logic             r_frame_done;

   logic [IDX_W:0]   w_cand;
   logic [IDX_W-1:0] w_sel;
   logic             w_found;
   logic             w_accept;

   // Search upward from the requester after the last winner, wrapping at NUM_REQ.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = {1'b0, r_last} + (IDX_W+1)'(k);
         if (w_cand >= c_num_req) begin
            w_cand = w_cand - c_num_req;
         end
         if (!w_found && req_valid[w_cand[IDX_W-1:0]]) begin
            w_found = 1'b1;
            w_sel   = w_cand[IDX_W-1:0];
         end
      end
   end

   assign w_accept = rst_n && enable && (r_state == S_IDLE) && w_found;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
      assign req_ready[i] = w_accept && (w_sel == IDX_W'(i));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_last       <= c_last_init;
         r_grant_id   <= '0;
         r_tx_data    <= 8'h00;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_tx_data  <= req_data[8*w_sel +: 8];
                  r_grant_id <= w_sel;
                  r_last     <= w_sel;
                  r_busy     <= 1'b1;
                  r_state    <= S_TRIG;
               end
            end
            S_TRIG: begin
               r_cnt   <= '0;
               r_state <= S_SEND;
            end
            S_SEND: begin
               if (r_cnt == c_send_last) begin
                  r_cnt <= '0;
                  if (c_has_gap) begin
                     r_state <= S_GAP;
                  end else begin
                     r_state      <= S_IDLE;
                     r_busy       <= 1'b0;
                     r_frame_done <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (r_cnt == c_gap_last) begin
                  r_cnt        <= '0;
                  r_state      <= S_IDLE;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_trigger = (r_state == S_TRIG);
   assign tx_data    = r_tx_data;
   assign grant_id   = r_grant_id;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;

endmodule
`default_nettype wire
